prog_fetch_unit: RTL and testbench
==================================

Name: prog_fetch_unit

Overview:
Parametrised instruction-fetch unit for the simple processor. It combines byte-addressed instruction storage, a byte-serial load/readback port for the I2C programming path, and a program counter with stall, branch and fault handling. Mode control is an explicit state machine. It replaces the fixed 8-bit PC plus 32-bit instruction-memory pairing with a width- and depth-configurable block that sits between the programming interface and the core decode stage.

Parameters:
ADDR_W, 8, byte-address width of the PC, load pointer and branch target.
INSTR_W, 32, instruction width in bits; must be a multiple of 8. BYTES = INSTR_W/8 (localparam).
DEPTH, 64, number of instruction words; DEPTH*BYTES must be ≤ 2^ADDR_W. LIMIT = DEPTH*BYTES (localparam).

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous reset, active low
i_prog_mode  in  1  1 = programming requested, 0 = run/halt
i_run  in  1  1 = execute while not in programming mode
i_ld_addr_valid  in  1  load new byte pointer from i_ld_addr
i_ld_addr  in  ADDR_W  byte pointer value
i_ld_valid  in  1  byte write request
i_ld_byte  in  8  byte to write
o_ld_ready  out  1  byte write accepted this cycle
i_rd_req  in  1  readback request
o_rd_byte  out  8  readback data
o_rd_valid  out  1  readback data valid (1-cycle pulse)
i_stall  in  1  hold fetch outputs
i_branch  in  1  redirect PC
i_branch_target  in  ADDR_W  branch byte address
o_pc  out  ADDR_W  address of o_instr
o_instr  out  INSTR_W  fetched instruction
o_instr_valid  out  1  o_instr valid
o_fault  out  1  sticky fault flag

Behaviour:
- Reset (async): state HALT; pc, ptr, o_pc, o_instr, o_rd_byte = 0; o_instr_valid, o_rd_valid, o_fault = 0. Memory contents are not reset.
- Memory layout: word = addr/BYTES, lane = addr%BYTES, little-endian (lane 0 = bits 7:0). All writes are single-byte writes.
- States and transitions:
  - HALT → PROG when i_prog_mode = 1.
  - HALT → RUN when i_prog_mode = 0 and i_run = 1.
  - PROG → HALT when i_prog_mode = 0; pc is cleared to 0 on this transition.
  - RUN → PROG when i_prog_mode = 1; fetch is aborted and o_instr_valid cleared.
  - RUN → HALT when i_run = 0 (pc is kept) or on a fault.
  - i_prog_mode has priority over i_run in all states.
- PROG, load pointer:
  - i_ld_addr_valid: ptr <= i_ld_addr.
  - If i_ld_addr ≥ LIMIT: ptr is unchanged and o_fault is set.
- PROG, byte write:
  - o_ld_ready = (state == PROG) & !i_ld_addr_valid (combinational).
  - Handshake when i_ld_valid & o_ld_ready: mem[ptr] <= i_ld_byte; ptr <= ptr+1, wrapping from LIMIT-1 to 0.
- PROG, readback:
  - i_rd_req is honoured only with no ld handshake and no i_ld_addr_valid in the same cycle; otherwise it is dropped.
  - When honoured: next cycle o_rd_byte = mem[ptr] and o_rd_valid = 1; ptr increments with the same wrap.
- RUN, fetch (1-cycle latency): each cycle with !i_stall and !i_branch:
  - o_pc <= pc; o_instr <= word[pc/BYTES]; o_instr_valid <= 1.
  - pc <= pc+BYTES, wrapping at LIMIT to 0.
- Stall: o_pc, o_instr, o_instr_valid and pc all hold.
- Branch: i_branch in RUN takes priority over i_stall.
  - Valid target (aligned, < LIMIT): pc <= target; o_instr_valid <= 0 next cycle (flush). Fetch from target follows in the next non-stalled cycle.
  - Invalid target (target%BYTES ≠ 0 or target ≥ LIMIT): o_fault <= 1, state → HALT, o_instr_valid <= 0, pc unchanged.
- Outside RUN, o_instr_valid = 0 (registered, cleared in the first cycle after leaving RUN).
- o_fault clears only on reset or on entry to PROG.
- Reset asserted mid-operation: immediate return to reset values; any partially written word keeps the bytes already written.

Test Plan:
1. Assert i_nrst = 0 then release, i_prog_mode = 0, i_run = 0 → o_pc = 0, o_instr_valid = 0, o_ld_ready = 0, o_fault = 0.
2. PROG: set ptr 0, write bytes 0x11..0x88 back-to-back → o_ld_ready high throughout. Reset ptr to 0 and issue 8 i_rd_req → o_rd_byte sequence 0x11..0x88, one cycle after each request.
3. Leave PROG, i_run = 1 → first valid cycle o_pc = 0, o_instr = 0x44332211; next cycle o_pc = 4, o_instr = 0x88776655.
4. Hold i_stall = 1 for 3 cycles mid-run → o_pc, o_instr, o_instr_valid unchanged. Assert i_branch = 1 with target 0 during the stall → flush cycle with valid = 0, then o_pc = 0.
5. Branch to 0x02 → o_fault = 1, state HALT, o_instr_valid = 0. Enter PROG → o_fault = 0. With ADDR_W = 10, load ptr 0x100 → o_fault = 1, ptr unchanged.
6. Wrap: pc = 252 (defaults) → next o_pc = 0. Load ptr 255, write one byte → following readback returns mem[0]. Simultaneous i_ld_addr_valid with i_ld_valid → o_ld_ready = 0, no write.

Source files
------------

// File: rtl/prog_fetch_unit.sv
// Instruction-fetch unit: byte-wide instruction store with a programming/readback
// port, a program counter with stall/branch/fault handling and a HALT/PROG/RUN FSM.
module prog_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 64
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_prog_mode,
    input  logic               i_run,
    input  logic               i_ld_addr_valid,
    input  logic [ADDR_W-1:0]  i_ld_addr,
    input  logic               i_ld_valid,
    input  logic [7:0]         i_ld_byte,
    output logic               o_ld_ready,
    input  logic               i_rd_req,
    output logic [7:0]         o_rd_byte,
    output logic               o_rd_valid,
    input  logic               i_stall,
    input  logic               i_branch,
    input  logic [ADDR_W-1:0]  i_branch_target,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_instr_valid,
    output logic               o_fault
);

    localparam int BYTES = INSTR_W / 8;
    localparam int LIMIT = DEPTH * BYTES;
    localparam int IDX_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    // Bounds compared one bit wider so LIMIT == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   LIMIT_X   = (ADDR_W+1)'(LIMIT);
    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(LIMIT - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(LIMIT - BYTES);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BYTES);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_PROG = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  ptr_r;
    logic [7:0]         mem_r [LIMIT];

    logic               ld_hs_s;
    logic               addr_ok_s;
    logic               target_ok_s;
    logic [ADDR_W-1:0]  ptr_inc_s;
    logic [ADDR_W-1:0]  pc_inc_s;
    logic [INSTR_W-1:0] fetch_word_s;

    // Handshake, bounds checks and pointer/PC increments with wrap.
    always_comb begin
        o_ld_ready  = (state_r == ST_PROG) && !i_ld_addr_valid;
        ld_hs_s     = i_ld_valid && o_ld_ready;
        addr_ok_s   = {1'b0, i_ld_addr} < LIMIT_X;
        target_ok_s = ({1'b0, i_branch_target} < LIMIT_X) &&
                      ((i_branch_target % STEP) == ADDR_W'(0));
        if (ptr_r == LAST_BYTE) begin
            ptr_inc_s = ADDR_W'(0);
        end else begin
            ptr_inc_s = ptr_r + ADDR_W'(1);
        end
        if (pc_r == LAST_WORD) begin
            pc_inc_s = ADDR_W'(0);
        end else begin
            pc_inc_s = pc_r + STEP;
        end
    end

    // Little-endian word assembly from the byte store at the current PC.
    always_comb begin
        fetch_word_s = '0;
        for (int b = 0; b < BYTES; b++) begin
            fetch_word_s[8*b +: 8] = mem_r[pc_r[IDX_W-1:0] + IDX_W'(b)];
        end
    end

    // Next-state logic; programming request always wins over run.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_HALT: begin
                if (i_prog_mode) begin
                    state_s = ST_PROG;
                end else if (i_run) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HALT;
                end
            end
            ST_PROG: begin
                if (!i_prog_mode) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_PROG;
                end
            end
            ST_RUN: begin
                if (i_prog_mode) begin
                    state_s = ST_PROG;
                end else if (!i_run || (i_branch && !target_ok_s)) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_HALT;
        endcase
    end

    // Byte store; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (ld_hs_s) begin
            mem_r[ptr_r[IDX_W-1:0]] <= i_ld_byte;
        end
    end

    // State, pointers and all registered outputs.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_r       <= ST_HALT;
            pc_r          <= '0;
            ptr_r         <= '0;
            o_pc          <= '0;
            o_instr       <= '0;
            o_instr_valid <= 1'b0;
            o_rd_byte     <= 8'h00;
            o_rd_valid    <= 1'b0;
            o_fault       <= 1'b0;
        end else begin
            state_r    <= state_s;
            o_rd_valid <= 1'b0;
            case (state_r)
                ST_HALT: begin
                    o_instr_valid <= 1'b0;
                    if (i_prog_mode) begin
                        o_fault <= 1'b0;
                    end
                end
                ST_PROG: begin
                    o_instr_valid <= 1'b0;
                    if (!i_prog_mode) begin
                        pc_r <= '0;
                    end
                    if (i_ld_addr_valid) begin
                        if (addr_ok_s) begin
                            ptr_r <= i_ld_addr;
                        end else begin
                            o_fault <= 1'b1;
                        end
                    end else if (i_ld_valid) begin
                        ptr_r <= ptr_inc_s;
                    end else if (i_rd_req) begin
                        o_rd_byte  <= mem_r[ptr_r[IDX_W-1:0]];
                        o_rd_valid <= 1'b1;
                        ptr_r      <= ptr_inc_s;
                    end
                end
                ST_RUN: begin
                    if (i_prog_mode) begin
                        o_instr_valid <= 1'b0;
                        o_fault       <= 1'b0;
                    end else if (!i_run) begin
                        o_instr_valid <= 1'b0;
                    end else if (i_branch) begin
                        o_instr_valid <= 1'b0;
                        if (target_ok_s) begin
                            pc_r <= i_branch_target;
                        end else begin
                            o_fault <= 1'b1;
                        end
                    end else if (!i_stall) begin
                        o_pc          <= pc_r;
                        o_instr       <= fetch_word_s;
                        o_instr_valid <= 1'b1;
                        pc_r          <= pc_inc_s;
                    end
                end
                default: begin
                    o_instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Directed bench for prog_fetch_unit (ADDR_W = 10, 32-bit words, 64 words).
module tb_prog_fetch_unit;

    localparam int AW = 10;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          nrst;
    logic          prog_mode, run, ld_addr_valid, ld_valid, rd_req, stall, branch;
    logic [AW-1:0] ld_addr, branch_target;
    logic [7:0]    ld_byte;
    logic          ld_ready, rd_valid, instr_valid, fault;
    logic [7:0]    rd_byte;
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;

    int n_vec = 0;
    int n_err = 0;

    prog_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(64)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_prog_mode(prog_mode), .i_run(run),
        .i_ld_addr_valid(ld_addr_valid), .i_ld_addr(ld_addr),
        .i_ld_valid(ld_valid), .i_ld_byte(ld_byte), .o_ld_ready(ld_ready),
        .i_rd_req(rd_req), .o_rd_byte(rd_byte), .o_rd_valid(rd_valid),
        .i_stall(stall), .i_branch(branch), .i_branch_target(branch_target),
        .o_pc(pc), .o_instr(instr), .o_instr_valid(instr_valid), .o_fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ptr(input logic [AW-1:0] a);
        ld_addr_valid = 1'b1;
        ld_addr       = a;
        step();
        ld_addr_valid = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_byte  = b;
        #1;
        chk("ld_ready_wr", 64'(ld_ready), 64'd1);
        step();
        ld_valid = 1'b0;
    endtask

    task automatic rd_one(input string tag, input logic [7:0] exp);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk({tag, "_v"}, 64'(rd_valid), 64'd1);
        chk(tag, 64'(rd_byte), 64'(exp));
    endtask

    initial begin
        nrst = 1'b0; prog_mode = 1'b0; run = 1'b0; ld_addr_valid = 1'b0; ld_valid = 1'b0;
        rd_req = 1'b0; stall = 1'b0; branch = 1'b0; ld_addr = '0; branch_target = '0;
        ld_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        nrst = 1'b1;
        step();

        // Program bytes 0x11..0x88 and read them back.
        prog_mode = 1'b1;
        step();
        chk("prog_ld_ready", 64'(ld_ready), 64'd1);
        set_ptr(10'd0);
        for (int i = 0; i < 8; i++) wr_byte(8'((i + 1) * 8'h11));
        set_ptr(10'd0);
        rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rd_valid", 64'(rd_valid), 64'd1);
            chk("rd_byte", 64'(rd_byte), 64'((i + 1) * 8'h11));
        end
        rd_req = 1'b0;
        step();
        chk("rd_pulse_end", 64'(rd_valid), 64'd0);

        // Run from 0.
        prog_mode = 1'b0;
        step();
        run = 1'b1;
        step();
        chk("run_entry_valid", 64'(instr_valid), 64'd0);
        step();
        chk("f0_pc", 64'(pc), 64'd0);
        chk("f0_instr", 64'(instr), 64'h44332211);
        chk("f0_valid", 64'(instr_valid), 64'd1);
        step();
        chk("f1_pc", 64'(pc), 64'd4);
        chk("f1_instr", 64'(instr), 64'h88776655);

        // Stall three cycles, then branch to 0 during the stall.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", 64'(pc), 64'd4);
            chk("stall_instr", 64'(instr), 64'h88776655);
            chk("stall_valid", 64'(instr_valid), 64'd1);
        end
        branch = 1'b1; branch_target = 10'd0;
        step();
        chk("flush_valid", 64'(instr_valid), 64'd0);
        branch = 1'b0; stall = 1'b0;
        step();
        chk("br0_pc", 64'(pc), 64'd0);
        chk("br0_instr", 64'(instr), 64'h44332211);
        chk("br0_fault", 64'(fault), 64'd0);

        // Misaligned branch faults and halts with PC unchanged.
        branch = 1'b1; branch_target = 10'd2;
        step();
        branch = 1'b0;
        chk("badbr_fault", 64'(fault), 64'd1);
        chk("badbr_valid", 64'(instr_valid), 64'd0);
        step();
        chk("halted_valid", 64'(instr_valid), 64'd0);
        step();
        chk("resume_pc", 64'(pc), 64'd4);
        chk("resume_instr", 64'(instr), 64'h88776655);
        chk("fault_sticky", 64'(fault), 64'd1);
        run = 1'b0;
        step();
        chk("run_off_valid", 64'(instr_valid), 64'd0);
        prog_mode = 1'b1;
        step();
        chk("prog_clr_fault", 64'(fault), 64'd0);
        set_ptr(10'd3);
        set_ptr(10'h100);
        chk("ptr_oob_fault", 64'(fault), 64'd1);
        rd_one("ptr_kept", 8'h44);

        // Fill last word, wrap the load pointer, blocked simultaneous write.
        set_ptr(10'd252);
        wr_byte(8'hA1); wr_byte(8'hB2); wr_byte(8'hC3);
        set_ptr(10'd255);
        wr_byte(8'hD4);
        rd_one("ptr_wrap", 8'h11);
        ld_addr_valid = 1'b1; ld_addr = 10'd0; ld_valid = 1'b1; ld_byte = 8'hFF;
        #1;
        chk("ld_ready_blocked", 64'(ld_ready), 64'd0);
        step();
        ld_addr_valid = 1'b0; ld_valid = 1'b0;
        rd_one("no_write", 8'h11);

        // PC wrap from 252 to 0.
        prog_mode = 1'b0;
        step();
        run = 1'b1;
        step();
        branch = 1'b1; branch_target = 10'd252;
        step();
        branch = 1'b0;
        chk("br252_flush", 64'(instr_valid), 64'd0);
        step();
        chk("w252_pc", 64'(pc), 64'd252);
        chk("w252_instr", 64'(instr), 64'hD4C3B2A1);
        step();
        chk("wrap_pc", 64'(pc), 64'd0);
        chk("wrap_instr", 64'(instr), 64'h44332211);

        // Abort to PROG, then asynchronous reset mid-operation.
        prog_mode = 1'b1;
        step();
        chk("abort_valid", 64'(instr_valid), 64'd0);
        chk("abort_fault", 64'(fault), 64'd0);
        chk("abort_ld_ready", 64'(ld_ready), 64'd1);
        set_ptr(10'h3FF);
        chk("oob2_fault", 64'(fault), 64'd1);
        #2;
        nrst = 1'b0;
        #1;
        chk("async_fault", 64'(fault), 64'd0);
        chk("async_ld_ready", 64'(ld_ready), 64'd0);
        chk("async_pc", 64'(pc), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
